// File: rtl/seq_align_shifter.sv
// Multi-cycle one-bit-per-clock shifter for FP adder exponent alignment and normalisation.
// Right shifts collect guard/sticky; Start/Busy/Done handshake plus a count of shifts performed.
module seq_align_shifter #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Clear,
  input  logic             Start,
  input  logic [WIDTH-1:0] Data,
  input  logic [CNT_W-1:0] Count,
  input  logic [1:0]       Mode,
  output logic [WIDTH-1:0] Result,
  output logic             Guard,
  output logic             Sticky,
  output logic [CNT_W-1:0] Shift_amt,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_RIGHT = 2'b00;
  localparam logic [1:0] MODE_LEFT  = 2'b01;
  localparam logic [1:0] MODE_NORM  = 2'b10;

  localparam logic [CNT_W-1:0] RIGHT_MAX = CNT_W'(WIDTH + 1);
  localparam logic [CNT_W-1:0] LEFT_MAX  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             guard_q, guard_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] amt_q, amt_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [1:0]       mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept;
  logic             finish;

  function automatic logic [CNT_W-1:0] clip_count(input logic [CNT_W-1:0] cnt,
                                                  input logic [CNT_W-1:0] lim);
    return (cnt >= lim) ? lim : cnt;
  endfunction

  // Start is only honoured outside SHIFT, so DONE can chain straight into a new operation.
  assign accept = Start && (state_q != ST_SHIFT);

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    amt_d    = amt_q;
    n_d      = n_q;
    mode_d   = mode_q;
    busy_d   = busy_q;
    done_d   = done_q;
    finish   = 1'b0;

    case (state_q)
      ST_SHIFT: begin
        amt_d = amt_q + ONE;
        n_d   = n_q - ONE;
        case (mode_q)
          MODE_RIGHT: begin
            sticky_d = sticky_q | guard_q;
            guard_d  = result_q[0];
            result_d = result_q >> 1;
            finish   = (n_q == ONE);
          end
          MODE_LEFT: begin
            result_d = result_q << 1;
            finish   = (n_q == ONE);
          end
          MODE_NORM: begin
            // Stop once the bit about to land in the MSB is a one.
            result_d = result_q << 1;
            finish   = result_q[WIDTH-2];
          end
          default: finish = 1'b1;
        endcase
        if (finish) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        if (accept) begin
          result_d = Data;
          guard_d  = 1'b0;
          sticky_d = 1'b0;
          amt_d    = '0;
          mode_d   = Mode;
          case (Mode)
            MODE_RIGHT: n_d = clip_count(Count, RIGHT_MAX);
            MODE_LEFT:  n_d = clip_count(Count, LEFT_MAX);
            MODE_NORM:  n_d = (Data[WIDTH-1] || (Data == '0)) ? '0 : ONE;
            default:    n_d = '0;
          endcase
          if (n_d != '0) begin
            state_d = ST_SHIFT;
            busy_d  = 1'b1;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Clear) begin
    if (Clear) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      amt_q    <= '0;
      n_q      <= '0;
      mode_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      amt_q    <= amt_d;
      n_q      <= n_d;
      mode_q   <= mode_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Result    = result_q;
  assign Guard     = guard_q;
  assign Sticky    = sticky_q;
  assign Shift_amt = amt_q;
  assign Busy      = busy_q;
  assign Done      = done_q;

endmodule

// File: tb/tb_seq_align_shifter.sv
// Directed bench for seq_align_shifter: right/left/normalise/pass modes, saturation,
// back-to-back starts, ignored starts while busy, and asynchronous clear mid-shift.
module tb_seq_align_shifter;
  localparam int W  = 24;
  localparam int CW = 8;

  logic          Clk = 1'b0;
  logic          Clear;
  logic          Start;
  logic [W-1:0]  Data;
  logic [CW-1:0] Count;
  logic [1:0]    Mode;
  logic [W-1:0]  Result;
  logic          Guard;
  logic          Sticky;
  logic [CW-1:0] Shift_amt;
  logic          Busy;
  logic          Done;

  int checks = 0;
  int errors = 0;

  seq_align_shifter #(.WIDTH(W), .CNT_W(CW)) dut (
    .Clk(Clk), .Clear(Clear), .Start(Start), .Data(Data), .Count(Count), .Mode(Mode),
    .Result(Result), .Guard(Guard), .Sticky(Sticky), .Shift_amt(Shift_amt),
    .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  // Drive Start from the current negedge; returns at the negedge after the accepting edge.
  task automatic launch(input logic [1:0] m, input logic [W-1:0] d, input logic [CW-1:0] c);
    Start = 1'b1; Mode = m; Data = d; Count = c;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic start_op(input logic [1:0] m, input logic [W-1:0] d, input logic [CW-1:0] c);
    @(negedge Clk);
    launch(m, d, c);
  endtask

  // lat = cycles after the accepting edge before Done is seen; bsy = cycles with Busy high.
  task automatic wait_done(output int lat, output int bsy);
    lat = 0; bsy = 0;
    while (Done !== 1'b1 && lat < 60) begin
      if (Busy === 1'b1) bsy++;
      lat++;
      @(negedge Clk);
    end
    checks++;
    if (Done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout got Done=%b after %0d cycles", Done, lat);
    end
  endtask

  task automatic test_reset();
    Clear = 1'b1; Start = 1'b0; Data = '0; Count = '0; Mode = 2'b00;
    #12;
    checks++;
    if ({Result, Guard, Sticky, Shift_amt, Busy, Done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got R=%h G=%b S=%b A=%0d B=%b D=%b required all 0",
               Result, Guard, Sticky, Shift_amt, Busy, Done);
    end
    @(negedge Clk); Clear = 1'b0;
    @(negedge Clk);
    checks++;
    if ({Result, Busy, Done} !== '0) begin
      errors++;
      $display("FAIL reset_idle got R=%h B=%b D=%b required 0", Result, Busy, Done);
    end
  endtask

  task automatic test_right();
    int lat, bsy;
    start_op(2'b00, 24'hC00001, 8'd3);
    wait_done(lat, bsy);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL right3_latency got %0d required 3", lat); end
    checks++;
    if (bsy != 3) begin errors++; $display("FAIL right3_busy got %0d required 3", bsy); end
    checks++;
    if ({Result, Guard, Sticky, Shift_amt} !== {24'h180000, 1'b0, 1'b1, 8'd3}) begin
      errors++;
      $display("FAIL right3_out got R=%h G=%b S=%b A=%0d required 180000 0 1 3",
               Result, Guard, Sticky, Shift_amt);
    end
    @(negedge Clk);
    checks++;
    if (Done !== 1'b0 || Result !== 24'h180000) begin
      errors++;
      $display("FAIL right3_hold got D=%b R=%h required 0 180000", Done, Result);
    end
  endtask

  task automatic test_right_sat();
    int lat, bsy;
    start_op(2'b00, 24'h800000, 8'd200);
    wait_done(lat, bsy);
    checks++;
    if (lat != 25 || bsy != 25) begin
      errors++;
      $display("FAIL rsat_latency got lat=%0d busy=%0d required 25 25", lat, bsy);
    end
    checks++;
    if ({Result, Guard, Sticky, Shift_amt} !== {24'h000000, 1'b0, 1'b1, 8'd25}) begin
      errors++;
      $display("FAIL rsat_out got R=%h G=%b S=%b A=%0d required 000000 0 1 25",
               Result, Guard, Sticky, Shift_amt);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bsy;
    start_op(2'b01, 24'h000FFF, 8'd4);
    wait_done(lat, bsy);
    checks++;
    if (lat != 4) begin errors++; $display("FAIL left4_latency got %0d required 4", lat); end
    checks++;
    if ({Result, Guard, Sticky, Shift_amt} !== {24'h00FFF0, 1'b0, 1'b0, 8'd4}) begin
      errors++;
      $display("FAIL left4_out got R=%h G=%b S=%b A=%0d required 00fff0 0 0 4",
               Result, Guard, Sticky, Shift_amt);
    end
    launch(2'b01, 24'hFFFFFF, 8'd24);
    checks++;
    if (Busy !== 1'b1 || Done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept got B=%b D=%b required 1 0", Busy, Done);
    end
    wait_done(lat, bsy);
    checks++;
    if (lat != 24) begin errors++; $display("FAIL lsat_latency got %0d required 24", lat); end
    checks++;
    if ({Result, Guard, Sticky, Shift_amt} !== {24'h000000, 1'b0, 1'b0, 8'd24}) begin
      errors++;
      $display("FAIL lsat_out got R=%h G=%b S=%b A=%0d required 000000 0 0 24",
               Result, Guard, Sticky, Shift_amt);
    end
  endtask

  task automatic test_normalise();
    int lat, bsy;
    start_op(2'b10, 24'h000123, 8'd0);
    wait_done(lat, bsy);
    checks++;
    if (lat != 15) begin errors++; $display("FAIL norm_latency got %0d required 15", lat); end
    checks++;
    if ({Result, Shift_amt} !== {24'h918000, 8'd15}) begin
      errors++;
      $display("FAIL norm_out got R=%h A=%0d required 918000 15", Result, Shift_amt);
    end
    start_op(2'b10, 24'h800000, 8'd9);
    wait_done(lat, bsy);
    checks++;
    if (lat != 0 || bsy != 0 || {Result, Shift_amt} !== {24'h800000, 8'd0}) begin
      errors++;
      $display("FAIL norm_msb got lat=%0d busy=%0d R=%h A=%0d required 0 0 800000 0",
               lat, bsy, Result, Shift_amt);
    end
    start_op(2'b10, 24'h000000, 8'd9);
    wait_done(lat, bsy);
    checks++;
    if (lat != 0 || bsy != 0 || {Result, Shift_amt} !== {24'h000000, 8'd0}) begin
      errors++;
      $display("FAIL norm_zero got lat=%0d busy=%0d R=%h A=%0d required 0 0 000000 0",
               lat, bsy, Result, Shift_amt);
    end
  endtask

  task automatic test_pass();
    int lat, bsy;
    start_op(2'b11, 24'hABCDEF, 8'd7);
    wait_done(lat, bsy);
    checks++;
    if (lat != 0 || bsy != 0 || {Result, Shift_amt} !== {24'hABCDEF, 8'd0}) begin
      errors++;
      $display("FAIL pass_out got lat=%0d busy=%0d R=%h A=%0d required 0 0 abcdef 0",
               lat, bsy, Result, Shift_amt);
    end
    start_op(2'b00, 24'hABCDEF, 8'd0);
    wait_done(lat, bsy);
    checks++;
    if (lat != 0 || bsy != 0 || {Result, Guard, Sticky, Shift_amt} !== {24'hABCDEF, 1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL zero_count got lat=%0d busy=%0d R=%h A=%0d required 0 0 abcdef 0",
               lat, bsy, Result, Shift_amt);
    end
  endtask

  task automatic test_ignore_start();
    int lat, bsy;
    start_op(2'b00, 24'hABCDEF, 8'd10);
    // Hammer Start with a conflicting request while the shift runs.
    Start = 1'b1; Mode = 2'b01; Data = 24'h123456; Count = 8'd2;
    repeat (5) @(negedge Clk);
    Start = 1'b0;
    wait_done(lat, bsy);
    checks++;
    if (lat != 5) begin errors++; $display("FAIL ignore_latency got %0d required 5 more", lat); end
    checks++;
    if ({Result, Guard, Sticky, Shift_amt} !== {24'h002AF3, 1'b0, 1'b1, 8'd10}) begin
      errors++;
      $display("FAIL ignore_out got R=%h G=%b S=%b A=%0d required 002af3 0 1 10",
               Result, Guard, Sticky, Shift_amt);
    end
  endtask

  task automatic test_clear_mid_shift();
    int  lat, bsy;
    logic saw_done;
    start_op(2'b00, 24'hABCDEF, 8'd10);
    repeat (4) @(negedge Clk);
    #2 Clear = 1'b1;
    #1;
    checks++;
    if ({Result, Guard, Sticky, Shift_amt, Busy, Done} !== '0) begin
      errors++;
      $display("FAIL clear_async got R=%h G=%b S=%b A=%0d B=%b D=%b required all 0",
               Result, Guard, Sticky, Shift_amt, Busy, Done);
    end
    saw_done = 1'b0;
    repeat (2) begin
      @(negedge Clk);
      if (Done === 1'b1) saw_done = 1'b1;
    end
    Clear = 1'b0;
    repeat (12) begin
      @(negedge Clk);
      if (Done === 1'b1 || Busy === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0 || Result !== 24'h000000) begin
      errors++;
      $display("FAIL clear_quiet got activity=%b R=%h required 0 000000", saw_done, Result);
    end
    start_op(2'b00, 24'hC00001, 8'd3);
    wait_done(lat, bsy);
    checks++;
    if (lat != 3 || {Result, Guard, Sticky, Shift_amt} !== {24'h180000, 1'b0, 1'b1, 8'd3}) begin
      errors++;
      $display("FAIL clear_restart got lat=%0d R=%h G=%b S=%b A=%0d required 3 180000 0 1 3",
               lat, Result, Guard, Sticky, Shift_amt);
    end
  endtask

  initial begin
    test_reset();
    test_right();
    test_right_sat();
    test_back_to_back();
    test_normalise();
    test_pass();
    test_ignore_start();
    test_clear_mid_shift();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
